// File: rtl/jtframe_sdram_pkg.sv
// Shared types and widths for the jtframe SDRAM read-port arbiter.
//   ADDRW    : SDRAM word address width
//   DATAW    : SDRAM read data width
//   arb_st_t : arbiter FSM states
package jtframe_sdram_pkg;

  localparam int unsigned ADDRW = 22;
  localparam int unsigned DATAW = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_RDY
  } arb_st_t;

endpackage

// File: rtl/jtframe_rr_pick.sv
// Combinational round-robin encoder.
// Searches req starting at ptr+1, wrapping, and ends with ptr itself, so the
// slot granted last has the lowest priority.
//   req    : request vector, one bit per slot
//   ptr    : index of the slot granted last
//   winner : index of the selected slot (0 when nothing is found)
//   found  : at least one request bit is set
module jtframe_rr_pick #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [$clog2(NREQ)-1:0] winner,
  output logic                    found
);

  localparam int unsigned IDXW = $clog2(NREQ);

  int idx;

  // Walk the distances from farthest to nearest; the last hit written is the
  // nearest set bit after ptr, which is the round-robin winner.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = int'(NREQ); k >= 1; k--) begin
      idx = (int'(ptr) + k) % int'(NREQ);
      if (req[IDXW'(idx)]) begin
        winner = IDXW'(idx);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jtframe_sdram_arb.sv
// Round-robin arbiter sharing the SDRAM controller read port between NREQ ROM
// requesters. Lives in the clk_rom domain. With HIT_EN set, a read of the last
// word fetched is answered from the output register without an SDRAM access.
//   clk_rom, rst          : clock, asynchronous active-high reset
//   slot_req/slot_addr    : per-slot level request and packed 22-bit address
//   slot_ok/slot_dout     : one-cycle data-valid pulse and shared read data
//   sdram_req/sdram_ack   : address handshake towards the controller
//   sdram_addr            : address presented to the controller
//   data_read/data_rdy    : read data return from the controller
//   loop_rst              : controller in init loop, aborts any transaction
//   downloading           : ROM download active, blocks new grants
module jtframe_sdram_arb
  import jtframe_sdram_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter bit          HIT_EN = 1'b1
) (
  input  logic                  clk_rom,
  input  logic                  rst,
  input  logic [NREQ-1:0]       slot_req,
  input  logic [NREQ*ADDRW-1:0] slot_addr,
  output logic [NREQ-1:0]       slot_ok,
  output logic [DATAW-1:0]      slot_dout,
  output logic                  sdram_req,
  input  logic                  sdram_ack,
  output logic [ADDRW-1:0]      sdram_addr,
  input  logic [DATAW-1:0]      data_read,
  input  logic                  data_rdy,
  input  logic                  loop_rst,
  input  logic                  downloading
);

  localparam int unsigned IDXW = $clog2(NREQ);

  arb_st_t          state;
  logic [IDXW-1:0]  ptr;
  logic [IDXW-1:0]  winner;
  logic             hit_valid;
  logic [ADDRW-1:0] last_addr;

  logic [NREQ-1:0]  cand;
  logic [IDXW-1:0]  pick;
  logic             pick_found;
  logic [ADDRW-1:0] pick_addr;
  logic             pick_hit;
  logic [NREQ-1:0]  pick_mask;
  logic [NREQ-1:0]  win_mask;

  // A slot whose ok is pulsing this cycle is still shown as requesting, since
  // the requester only reacts to ok on the next edge; mask it out.
  assign cand = slot_req & ~slot_ok;

  jtframe_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req    (cand),
    .ptr    (ptr),
    .winner (pick),
    .found  (pick_found)
  );

  always_comb begin
    pick_addr = slot_addr[ADDRW*32'(pick) +: ADDRW];
    pick_hit  = HIT_EN && hit_valid && (pick_addr == last_addr);
    pick_mask = '0;
    pick_mask[pick] = 1'b1;
    win_mask  = '0;
    win_mask[winner] = 1'b1;
  end

  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= IDXW'(NREQ - 1);
      winner     <= '0;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      slot_ok    <= '0;
      slot_dout  <= '0;
      hit_valid  <= 1'b0;
      last_addr  <= '0;
    end else begin
      slot_ok <= '0;
      if (loop_rst) begin
        // Controller restarted: drop whatever was in flight. The requester
        // still holds slot_req and is granted again afterwards.
        state     <= IDLE;
        sdram_req <= 1'b0;
        hit_valid <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (!downloading && pick_found) begin
              ptr    <= pick;
              winner <= pick;
              if (pick_hit) begin
                slot_ok <= pick_mask;
              end else begin
                sdram_addr <= pick_addr;
                sdram_req  <= 1'b1;
                state      <= WAIT_ACK;
              end
            end
          end
          WAIT_ACK: begin
            if (sdram_ack) begin
              sdram_req <= 1'b0;
              // Data may arrive on the ack cycle; skip WAIT_RDY then.
              if (data_rdy) begin
                slot_dout <= data_read;
                last_addr <= sdram_addr;
                hit_valid <= 1'b1;
                slot_ok   <= win_mask;
                state     <= IDLE;
              end else begin
                state <= WAIT_RDY;
              end
            end
          end
          WAIT_RDY: begin
            if (data_rdy) begin
              slot_dout <= data_read;
              last_addr <= sdram_addr;
              hit_valid <= 1'b1;
              slot_ok   <= win_mask;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
        // ROM contents are being rewritten, so the cached word is stale.
        if (downloading) hit_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jtframe_sdram_arb.sv
module tb_jtframe_sdram_arb;

  localparam int NREQ = 4;
  localparam int AW   = 22;

  logic              clk_rom     = 1'b0;
  logic              rst         = 1'b1;
  logic [NREQ-1:0]   slot_req    = '0;
  logic [NREQ*AW-1:0] slot_addr  = '0;
  logic [NREQ-1:0]   slot_ok;
  logic [31:0]       slot_dout;
  logic              sdram_req;
  logic              sdram_ack   = 1'b0;
  logic [AW-1:0]     sdram_addr;
  logic [31:0]       data_read   = '0;
  logic              data_rdy    = 1'b0;
  logic              loop_rst    = 1'b0;
  logic              downloading = 1'b0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          slot;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  jtframe_sdram_arb #(
    .NREQ   (NREQ),
    .HIT_EN (1'b1)
  ) dut (
    .clk_rom     (clk_rom),
    .rst         (rst),
    .slot_req    (slot_req),
    .slot_addr   (slot_addr),
    .slot_ok     (slot_ok),
    .slot_dout   (slot_dout),
    .sdram_req   (sdram_req),
    .sdram_ack   (sdram_ack),
    .sdram_addr  (sdram_addr),
    .data_read   (data_read),
    .data_rdy    (data_rdy),
    .loop_rst    (loop_rst),
    .downloading (downloading)
  );

  always #5 clk_rom = ~clk_rom;

  // SDRAM contents seen by the controller model.
  function automatic logic [31:0] mem(input logic [AW-1:0] a);
    if (a == 22'h001234) return 32'hDEADBEEF;
    return {10'h2C5, a};
  endfunction

  task automatic set_addr(input int s, input logic [AW-1:0] a);
    slot_addr[AW*s +: AW] = a;
  endtask

  task automatic expect_ok(input int s, input logic [31:0] d);
    exp_t e;
    e.slot = s;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    @(negedge clk_rom);
    @(negedge clk_rom);
    rst = 1'b0;
  endtask

  // Bounded wait for sdram_req, sampled on negedges.
  task automatic wait_req(output bit got);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (sdram_req === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk_rom);
    end
  endtask

  // Controller model: ack ack_dly cycles after req is seen, data rdy_dly cycles
  // after ack. Returns on the negedge where slot_ok should be visible.
  task automatic serve(input int ack_dly, input int rdy_dly, output bit got,
                       output logic [AW-1:0] seen);
    wait_req(got);
    seen = sdram_addr;
    if (!got) return;
    repeat (ack_dly) @(negedge clk_rom);
    sdram_ack = 1'b1;
    @(negedge clk_rom);
    sdram_ack = 1'b0;
    repeat (rdy_dly - 1) @(negedge clk_rom);
    data_read = mem(seen);
    data_rdy  = 1'b1;
    @(negedge clk_rom);
    data_rdy  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if (sdram_req !== 1'b0 || sdram_addr !== '0) begin
      errors++;
      $display("FAIL reset sdram: got req=%b addr=%h want 0/0", sdram_req, sdram_addr);
    end
    checks++;
    if (slot_ok !== '0 || slot_dout !== '0) begin
      errors++;
      $display("FAIL reset slot: got ok=%b dout=%h want 0/0", slot_ok, slot_dout);
    end
    @(negedge clk_rom);
    rst = 1'b0;
    repeat (2) @(negedge clk_rom);
    checks++;
    if (sdram_req !== 1'b0) begin
      errors++;
      $display("FAIL reset idle req: got %b want 0", sdram_req);
    end
  endtask

  task automatic test_single();
    bit got;
    logic [AW-1:0] seen;
    exp_t e;
    logic [3:0] m;
    set_addr(1, 22'h001234);
    slot_req = 4'b0010;
    expect_ok(1, 32'hDEADBEEF);
    @(negedge clk_rom);
    checks++;
    if (sdram_req !== 1'b1 || sdram_addr !== 22'h001234) begin
      errors++;
      $display("FAIL single issue: got req=%b addr=%h want 1/001234", sdram_req, sdram_addr);
    end
    serve(2, 4, got, seen);
    slot_req = 4'b0000;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL single req timeout: got none want sdram_req");
    end
    e = sb.pop_front();
    m = 4'b0001 << e.slot;
    checks++;
    if (slot_ok !== m || slot_dout !== e.data) begin
      errors++;
      $display("FAIL single ok: got %b/%h want %b/%h", slot_ok, slot_dout, m, e.data);
    end
    @(negedge clk_rom);
    checks++;
    if (slot_ok !== 4'b0000 || slot_dout !== 32'hDEADBEEF || sdram_req !== 1'b0) begin
      errors++;
      $display("FAIL single after: got ok=%b dout=%h req=%b want 0/deadbeef/0",
               slot_ok, slot_dout, sdram_req);
    end
  endtask

  task automatic test_fairness();
    bit got;
    logic [AW-1:0] seen;
    exp_t e;
    logic [3:0] m;
    int s;
    reset_dut();
    for (int i = 0; i < NREQ; i++) set_addr(i, 22'h000200 + 22'(i));
    slot_req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      s = k % NREQ;
      expect_ok(s, mem(22'h000200 + 22'(s)));
      serve(0, 1, got, seen);
      if (k == 5) slot_req = 4'b0000;
      checks++;
      if (!got || seen !== 22'h000200 + 22'(s)) begin
        errors++;
        $display("FAIL fair grant %0d: got addr=%h want %h", k, seen, 22'h000200 + 22'(s));
      end
      e = sb.pop_front();
      m = 4'b0001 << e.slot;
      checks++;
      if (slot_ok !== m || slot_dout !== e.data) begin
        errors++;
        $display("FAIL fair ok %0d: got %b/%h want %b/%h", k, slot_ok, slot_dout, m, e.data);
      end
    end
    repeat (3) @(negedge clk_rom);
    checks++;
    if (sdram_req !== 1'b0) begin
      errors++;
      $display("FAIL fair drain: got req=%b want 0", sdram_req);
    end
  endtask

  task automatic test_hit();
    bit got;
    logic [AW-1:0] seen;
    exp_t e;
    logic [3:0] m;
    set_addr(2, 22'h000100);
    slot_req = 4'b0100;
    expect_ok(2, mem(22'h000100));
    serve(1, 1, got, seen);
    set_addr(3, 22'h000100);
    slot_req = 4'b1000;
    e = sb.pop_front();
    m = 4'b0001 << e.slot;
    checks++;
    if (!got || slot_ok !== m || slot_dout !== e.data) begin
      errors++;
      $display("FAIL hit fill: got %b/%h want %b/%h", slot_ok, slot_dout, m, e.data);
    end
    expect_ok(3, mem(22'h000100));
    @(negedge clk_rom);
    slot_req = 4'b0000;
    e = sb.pop_front();
    m = 4'b0001 << e.slot;
    checks++;
    if (slot_ok !== m || slot_dout !== e.data || sdram_req !== 1'b0) begin
      errors++;
      $display("FAIL hit serve: got ok=%b dout=%h req=%b want %b/%h/0",
               slot_ok, slot_dout, sdram_req, m, e.data);
    end
    @(negedge clk_rom);
    checks++;
    if (slot_ok !== 4'b0000) begin
      errors++;
      $display("FAIL hit single pulse: got %b want 0000", slot_ok);
    end
    set_addr(3, 22'h000101);
    slot_req = 4'b1000;
    expect_ok(3, mem(22'h000101));
    @(negedge clk_rom);
    checks++;
    if (sdram_req !== 1'b1 || sdram_addr !== 22'h000101) begin
      errors++;
      $display("FAIL hit next miss: got req=%b addr=%h want 1/000101", sdram_req, sdram_addr);
    end
    serve(1, 1, got, seen);
    slot_req = 4'b0000;
    e = sb.pop_front();
    m = 4'b0001 << e.slot;
    checks++;
    if (!got || slot_ok !== m || slot_dout !== e.data) begin
      errors++;
      $display("FAIL hit miss data: got %b/%h want %b/%h", slot_ok, slot_dout, m, e.data);
    end
  endtask

  task automatic test_loop_rst();
    bit got;
    logic [AW-1:0] seen;
    exp_t e;
    logic [3:0] m;
    set_addr(1, 22'h000301);
    slot_req = 4'b0010;
    wait_req(got);
    sdram_ack = 1'b1;
    @(negedge clk_rom);
    sdram_ack = 1'b0;
    // In WAIT_RDY now; data arriving together with loop_rst must be dropped.
    loop_rst  = 1'b1;
    data_read = 32'h0BAD0BAD;
    data_rdy  = 1'b1;
    @(negedge clk_rom);
    data_rdy = 1'b0;
    checks++;
    if (!got || sdram_req !== 1'b0 || slot_ok !== 4'b0000) begin
      errors++;
      $display("FAIL loop abort: got req=%b ok=%b want 0/0000", sdram_req, slot_ok);
    end
    repeat (2) @(negedge clk_rom);
    checks++;
    if (sdram_req !== 1'b0 || slot_ok !== 4'b0000) begin
      errors++;
      $display("FAIL loop hold: got req=%b ok=%b want 0/0000", sdram_req, slot_ok);
    end
    loop_rst = 1'b0;
    @(negedge clk_rom);
    checks++;
    if (sdram_req !== 1'b1 || sdram_addr !== 22'h000301) begin
      errors++;
      $display("FAIL loop reissue: got req=%b addr=%h want 1/000301", sdram_req, sdram_addr);
    end
    expect_ok(1, mem(22'h000301));
    serve(1, 1, got, seen);
    slot_req = 4'b0000;
    e = sb.pop_front();
    m = 4'b0001 << e.slot;
    checks++;
    if (!got || slot_ok !== m || slot_dout !== e.data) begin
      errors++;
      $display("FAIL loop served: got %b/%h want %b/%h", slot_ok, slot_dout, m, e.data);
    end
    // A loop_rst pulse must forget the cached word: same address now misses.
    loop_rst = 1'b1;
    @(negedge clk_rom);
    loop_rst = 1'b0;
    set_addr(0, 22'h000301);
    slot_req = 4'b0001;
    expect_ok(0, mem(22'h000301));
    @(negedge clk_rom);
    checks++;
    if (sdram_req !== 1'b1 || slot_ok !== 4'b0000) begin
      errors++;
      $display("FAIL loop hit cleared: got req=%b ok=%b want 1/0000", sdram_req, slot_ok);
    end
    serve(1, 1, got, seen);
    slot_req = 4'b0000;
    e = sb.pop_front();
    m = 4'b0001 << e.slot;
    checks++;
    if (!got || slot_ok !== m || slot_dout !== e.data) begin
      errors++;
      $display("FAIL loop refetch: got %b/%h want %b/%h", slot_ok, slot_dout, m, e.data);
    end
  endtask

  task automatic test_downloading();
    bit got;
    logic [AW-1:0] seen;
    exp_t e;
    logic [3:0] m;
    set_addr(2, 22'h000400);
    slot_req = 4'b0100;
    wait_req(got);
    downloading = 1'b1;
    expect_ok(2, mem(22'h000400));
    serve(1, 2, got, seen);
    slot_req = 4'b0000;
    e = sb.pop_front();
    m = 4'b0001 << e.slot;
    checks++;
    if (!got || slot_ok !== m || slot_dout !== e.data) begin
      errors++;
      $display("FAIL dl inflight: got %b/%h want %b/%h", slot_ok, slot_dout, m, e.data);
    end
    @(negedge clk_rom);
    slot_req = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_rom);
      checks++;
      if (sdram_req !== 1'b0 || slot_ok !== 4'b0000) begin
        errors++;
        $display("FAIL dl blocked %0d: got req=%b ok=%b want 0/0000", i, sdram_req, slot_ok);
      end
    end
    downloading = 1'b0;
    @(negedge clk_rom);
    checks++;
    if (sdram_req !== 1'b1 || sdram_addr !== 22'h000400 || slot_ok !== 4'b0000) begin
      errors++;
      $display("FAIL dl repeat miss: got req=%b addr=%h ok=%b want 1/000400/0000",
               sdram_req, sdram_addr, slot_ok);
    end
    expect_ok(2, mem(22'h000400));
    serve(1, 1, got, seen);
    slot_req = 4'b0000;
    e = sb.pop_front();
    m = 4'b0001 << e.slot;
    checks++;
    if (!got || slot_ok !== m || slot_dout !== e.data) begin
      errors++;
      $display("FAIL dl refetch: got %b/%h want %b/%h", slot_ok, slot_dout, m, e.data);
    end
  endtask

  task automatic test_edges();
    bit got;
    logic [AW-1:0] seen;
    exp_t e;
    logic [3:0] m;
    // Stray data_rdy while idle.
    data_read = 32'hCAFEF00D;
    data_rdy  = 1'b1;
    @(negedge clk_rom);
    data_rdy  = 1'b0;
    checks++;
    if (slot_ok !== 4'b0000 || slot_dout !== mem(22'h000400)) begin
      errors++;
      $display("FAIL idle rdy: got ok=%b dout=%h want 0000/%h", slot_ok, slot_dout,
               mem(22'h000400));
    end
    // Ack and data in the same cycle.
    set_addr(3, 22'h000700);
    slot_req = 4'b1000;
    wait_req(got);
    expect_ok(3, mem(22'h000700));
    sdram_ack = 1'b1;
    data_read = mem(sdram_addr);
    data_rdy  = 1'b1;
    @(negedge clk_rom);
    sdram_ack = 1'b0;
    data_rdy  = 1'b0;
    slot_req  = 4'b0000;
    e = sb.pop_front();
    m = 4'b0001 << e.slot;
    checks++;
    if (!got || slot_ok !== m || slot_dout !== e.data || sdram_req !== 1'b0) begin
      errors++;
      $display("FAIL ack+rdy: got ok=%b dout=%h req=%b want %b/%h/0",
               slot_ok, slot_dout, sdram_req, m, e.data);
    end
    // Back in IDLE straight away; requester then drops and changes address.
    set_addr(1, 22'h000800);
    slot_req = 4'b0010;
    @(negedge clk_rom);
    checks++;
    if (sdram_req !== 1'b1 || sdram_addr !== 22'h000800) begin
      errors++;
      $display("FAIL b2b issue: got req=%b addr=%h want 1/000800", sdram_req, sdram_addr);
    end
    slot_req = 4'b0000;
    set_addr(1, 22'h000900);
    expect_ok(1, mem(22'h000800));
    serve(1, 1, got, seen);
    e = sb.pop_front();
    m = 4'b0001 << e.slot;
    checks++;
    if (!got || seen !== 22'h000800 || slot_ok !== m || slot_dout !== e.data) begin
      errors++;
      $display("FAIL drop after grant: got addr=%h ok=%b dout=%h want 000800/%b/%h",
               seen, slot_ok, slot_dout, m, e.data);
    end
  endtask

  task automatic test_async_rst();
    bit got;
    logic [AW-1:0] seen;
    exp_t e;
    logic [3:0] m;
    for (int i = 0; i < NREQ; i++) set_addr(i, 22'h000600 + 22'(i));
    slot_req = 4'b1111;
    wait_req(got);
    sdram_ack = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (!got || sdram_req !== 1'b0 || sdram_addr !== '0 || slot_ok !== '0 ||
        slot_dout !== '0) begin
      errors++;
      $display("FAIL async rst: got req=%b addr=%h ok=%b dout=%h want all 0",
               sdram_req, sdram_addr, slot_ok, slot_dout);
    end
    @(negedge clk_rom);
    rst = 1'b0;
    @(negedge clk_rom);
    checks++;
    if (sdram_req !== 1'b1 || sdram_addr !== 22'h000600) begin
      errors++;
      $display("FAIL rst first grant: got req=%b addr=%h want 1/000600", sdram_req, sdram_addr);
    end
    expect_ok(0, mem(22'h000600));
    serve(1, 1, got, seen);
    slot_req = 4'b0000;
    e = sb.pop_front();
    m = 4'b0001 << e.slot;
    checks++;
    if (!got || slot_ok !== m || slot_dout !== e.data) begin
      errors++;
      $display("FAIL rst served: got %b/%h want %b/%h", slot_ok, slot_dout, m, e.data);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard leftover: got %0d entries want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_hit();
    test_loop_rst();
    test_downloading();
    test_edges();
    test_async_rst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/jtframe_sdram_arb.md
Name: jtframe_sdram_arb

Overview:
- Round-robin arbiter sharing the single read port of the jtframe SDRAM controller (sdram_req/sdram_ack/sdram_addr/data_read/data_rdy) between NREQ ROM requesters (CPU, sound, char, scroll, obj).
- Sits between the game ROM fetch logic and the board-level SDRAM controller, in the clk_rom domain.
- Optional last-word hit register serves repeated reads without an SDRAM access.

Parameters:
- NREQ, 4, number of requester slots (2..8).
- HIT_EN, 1, enable last-word hit serving.

Ports:
- clk_rom  in  1  SDRAM-domain clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- slot_req  in  NREQ  level request per slot; held until its slot_ok pulse.
- slot_addr  in  NREQ*22  packed word addresses; slot i uses bits [22*i+21:22*i].
- slot_ok  out  NREQ  one-cycle data-valid pulse to the served slot.
- slot_dout  out  32  registered read data, shared by all slots, valid when any slot_ok is high and held until the next capture.
- sdram_req  out  1  request to controller.
- sdram_ack  in  1  controller accepted the address.
- sdram_addr  out  22  address to controller.
- data_read  in  32  controller read data.
- data_rdy  in  1  data_read valid.
- loop_rst  in  1  controller in init/reset loop.
- downloading  in  1  ROM download active.

Behaviour:
- Reset values: sdram_req=0, sdram_addr=0, slot_ok=0, slot_dout=0, state=IDLE, rr pointer=NREQ-1 (slot 0 wins first), hit_valid=0.
- States:
  - IDLE: if loop_rst or downloading is high, no grant. Otherwise candidates = slot_req & ~slot_ok; pick the first set bit searching from pointer+1 with wrap, register winner, set pointer=winner.
    - Hit case (HIT_EN=1, hit_valid, winner addr == last_addr): next cycle slot_ok[winner]=1 and slot_dout unchanged; stay IDLE.
    - Otherwise: sdram_addr <= winner addr, sdram_req <= 1, go to WAIT_ACK.
  - WAIT_ACK: hold sdram_req and sdram_addr. On sdram_ack: sdram_req <= 0, go to WAIT_RDY.
  - WAIT_RDY: on data_rdy: slot_dout <= data_read, last_addr <= sdram_addr, hit_valid <= 1, slot_ok[winner] <= 1 next cycle, go to IDLE.
- Latency, miss: req seen in IDLE at cycle 0; sdram_req high at cycle 1; slot_ok one cycle after data_rdy.
- Latency, hit: slot_ok at cycle 1.
- slot_ok is never high for more than one slot, and never for two consecutive cycles on the same slot.
- The slot_ok mask in IDLE prevents regranting a requester on the cycle its ok pulses.
- Requester drops slot_req after grant: the transaction completes and slot_ok still pulses.
- Address change after grant is ignored; the address is latched at grant.
- sdram_ack and data_rdy in the same cycle in WAIT_ACK: treat as ack then rdy; capture data and pulse ok with no WAIT_RDY cycle.
- data_rdy while IDLE: ignored.
- loop_rst high in any state: abort to IDLE, sdram_req=0, no slot_ok, hit_valid=0. The pending requester keeps requesting and is served afterwards.
- downloading high: the in-flight transaction completes normally; no new grants; hit_valid=0 (ROM contents changing).
- Async rst mid-transaction: immediate return to reset values.

Decomposition:
- Package jtframe_sdram_pkg:
  - ADDRW=22, DATAW=32.
  - Enum arb_st_t {IDLE, WAIT_ACK, WAIT_RDY}.
- Sub-module jtframe_rr_pick: combinational round-robin encoder.
  - Inputs: NREQ-bit request vector and pointer.
  - Outputs: winner index and found flag.
  - Reused by future write-port arbiters.

Test Plan:
- Single request: slot_req=4'b0010, addr 0x00_1234. Controller acks 2 cycles later and returns 0xDEADBEEF 4 cycles after ack. Required: sdram_addr=0x1234; slot_ok=4'b0010 one cycle after data_rdy; slot_dout=0xDEADBEEF.
- Fairness: all four slots held requesting continuously with distinct addresses. Required: grant order 0,1,2,3,0,1. No slot served twice before each other pending slot is served once.
- Hit: slot 2 reads 0x100, then slot 3 reads 0x100. Required: slot 3 gets slot_ok at cycle 1 with no sdram_req; a following read of 0x101 issues sdram_req.
- loop_rst asserted in WAIT_RDY. Required: sdram_req=0, no slot_ok, state IDLE. After loop_rst falls, the same slot is reissued and hit_valid=0.
- downloading rises during WAIT_ACK. Required: the current transaction finishes with slot_ok; no further sdram_req while downloading=1; a repeat of the last address misses afterwards.
- Async rst pulse mid-WAIT_ACK. Required: all outputs 0 immediately; first grant after release goes to slot 0 when all slots request.
